// File: rtl/tx_fcs_if.sv
// Serial bit-stream bundle around the FCS generator: payload in from the
// frame assembler, framed bits out to the zero-insertion stage.
interface tx_fcs_if;
    logic TxBit;
    logic TxBitValid;
    logic TxBitLast;
    logic TxBitReady;
    logic TxOut;
    logic TxOutValid;
    logic TxOutLast;
    logic OutReady;

    modport master (
        output TxBit, TxBitValid, TxBitLast, OutReady,
        input  TxBitReady, TxOut, TxOutValid, TxOutLast
    );

    modport slave (
        input  TxBit, TxBitValid, TxBitLast, OutReady,
        output TxBitReady, TxOut, TxOutValid, TxOutLast
    );
endinterface

// File: rtl/tx_fcs.sv
// HDLC transmit FCS generator: passes payload bits through one output slot
// and appends the 16-bit CRC (x^16+x^15+x^2+1) MSB first after the last bit.
module tx_fcs #(
    parameter logic [15:0] FCS_INIT = 16'h0000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic FCSen,
    input  logic StartFCS,
    input  logic Abort,
    output logic FCSBusy,
    tx_fcs_if.slave bus
);

    localparam int unsigned CRC_W = 16;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] APPEND = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d, crc_upd;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fcs_en_q, fcs_en_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             slot_free;
    logic             accept;
    logic             fb;

    assign slot_free      = !valid_q || bus.OutReady;
    assign accept         = (state_q == RUN) && slot_free && bus.TxBitValid;
    assign bus.TxBitReady = (state_q == RUN) && slot_free;
    assign bus.TxOut      = out_q;
    assign bus.TxOutValid = valid_q;
    assign bus.TxOutLast  = last_q;
    assign FCSBusy        = (state_q != IDLE);

    // Serial CRC step for one payload bit
    assign fb      = bus.TxBit ^ crc_q[15];
    assign crc_upd = {crc_q[14] ^ fb, crc_q[13:2], crc_q[1] ^ fb, crc_q[0], fb};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            crc_q    <= FCS_INIT;
            cnt_q    <= '0;
            fcs_en_q <= 1'b0;
            out_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            fcs_en_q <= fcs_en_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        fcs_en_d = fcs_en_q;
        out_d    = out_q;
        valid_d  = valid_q;
        last_d   = last_q;

        // A take empties the slot unless something reloads it below
        if (valid_q && bus.OutReady) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (StartFCS) begin
                    state_d  = RUN;
                    crc_d    = FCS_INIT;
                    fcs_en_d = FCSen;
                end
            end
            RUN: begin
                if (accept) begin
                    out_d   = bus.TxBit;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    crc_d   = crc_upd;
                    if (bus.TxBitLast) begin
                        if (fcs_en_q) begin
                            state_d = APPEND;
                            cnt_d   = CNT_W'(15);
                        end else begin
                            state_d = IDLE;
                            last_d  = 1'b1;
                        end
                    end
                end
            end
            APPEND: begin
                if (slot_free) begin
                    out_d   = crc_q[15];
                    crc_d   = {crc_q[14:0], 1'b0};
                    valid_d = 1'b1;
                    last_d  = (cnt_q == '0);
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort drops the frame and any pending output bit
        if (Abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            crc_d   = FCS_INIT;
        end
    end

endmodule

// File: tb/tb_tx_fcs.sv
// Directed/random bench for tx_fcs: expected output bits are queued as
// payload is driven and compared in order as the output slot is taken.
module tb_tx_fcs;

    logic Clk;
    logic Rst;
    logic FCSen;
    logic StartFCS;
    logic Abort;
    logic FCSBusy;

    tx_fcs_if bus();

    tx_fcs #(.FCS_INIT(16'h0000)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .FCSen    (FCSen),
        .StartFCS (StartFCS),
        .Abort    (Abort),
        .FCSBusy  (FCSBusy),
        .bus      (bus)
    );

    int   checks = 0;
    int   errors = 0;
    logic [1:0] exp_q[$];
    logic       obs_q[$];
    logic       mon_ignore = 1'b0;
    int         ign_takes  = 0;
    logic       rand_ready = 1'b0;
    logic       hold_pending = 1'b0;
    logic [1:0] hold_val = 2'b00;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference bitwise polynomial division, message shifted by x^16
    function automatic logic [15:0] crc_bit(input logic [15:0] r, input logic b);
        return {r[14:0], 1'b0} ^ (((b ^ r[15]) == 1'b1) ? 16'h8005 : 16'h0000);
    endfunction

    // Downstream ready: held at 1 unless random stalling is enabled
    initial begin
        bus.OutReady = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            bus.OutReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: sampled on the falling edge, a valid bit with OutReady
    // high is the bit taken at the next rising edge.
    always @(negedge Clk) begin
        logic [1:0] e;
        if (!Rst) begin
            if (hold_pending && !mon_ignore)
                chk("stall_hold", 32'({bus.TxOutValid, bus.TxOut, bus.TxOutLast}),
                    32'({1'b1, hold_val}));
            if (bus.TxOutValid && !bus.OutReady && !mon_ignore)
                chk("ready_when_full", 32'(bus.TxBitReady), 32'd0);
            if (bus.TxOutValid && bus.OutReady) begin
                obs_q.push_back(bus.TxOut);
                if (mon_ignore) begin
                    ign_takes++;
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(bus.TxOutValid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_bit", 32'({bus.TxOut, bus.TxOutLast}), 32'(e));
                end
            end
            hold_pending = bus.TxOutValid && !bus.OutReady;
            hold_val     = {bus.TxOut, bus.TxOutLast};
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic send_bit(input logic b, input logic last);
        int n = 0;
        bus.TxBit      = b;
        bus.TxBitValid = 1'b1;
        bus.TxBitLast  = last;
        @(negedge Clk);
        while (!bus.TxBitReady && n < 500) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 500) chk("send_timeout", 32'(bus.TxBitReady), 32'd1);
        @(posedge Clk);
        #1;
        bus.TxBitValid = 1'b0;
        bus.TxBitLast  = 1'b0;
    endtask

    task automatic run_frame(input logic en, input int n, input logic [63:0] bits, input logic push);
        logic [15:0] r = 16'h0000;
        StartFCS = 1'b1;
        FCSen    = en;
        @(posedge Clk);
        #1;
        StartFCS = 1'b0;
        for (int i = 0; i < n; i++) begin
            r = crc_bit(r, bits[i]);
            if (push) exp_q.push_back({bits[i], (i == n - 1) && !en});
            send_bit(bits[i], i == n - 1);
        end
        if (en && push) begin
            for (int k = 15; k >= 0; k--) exp_q.push_back({r[k], k == 0});
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [15:0] fcs;
        logic [15:0] r;
        logic [63:0] rnd;
        int cyc;
        int vcnt;

        Rst = 1'b1; FCSen = 1'b0; StartFCS = 1'b0; Abort = 1'b0;
        bus.TxBit = 1'b0; bus.TxBitValid = 1'b1; bus.TxBitLast = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;

        // Reset values; payload offered in IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("rst_valid", 32'(bus.TxOutValid), 32'd0);
            chk("rst_last",  32'(bus.TxOutLast),  32'd0);
            chk("rst_out",   32'(bus.TxOut),      32'd0);
            chk("rst_busy",  32'(FCSBusy),        32'd0);
            chk("rst_ready", 32'(bus.TxBitReady), 32'd0);
        end
        bus.TxBitValid = 1'b0;
        @(posedge Clk);
        #1;

        // Single payload bit 1: FCS 16'h8005, 17 gapless bits, busy drops with last load
        obs_q.delete();
        run_frame(1'b1, 1, 64'h1, 1'b1);
        cyc = 0; vcnt = 0;
        while (cyc < 40) begin
            @(negedge Clk);
            cyc++;
            if (bus.TxOutValid) vcnt++;
            if (cyc == 16) chk("t1_busy_before_last", 32'(FCSBusy), 32'd1);
            if (bus.TxOutLast) break;
        end
        chk("t1_cycles", 32'(cyc), 32'd17);
        chk("t1_valid_cycles", 32'(vcnt), 32'd17);
        chk("t1_busy_at_last", 32'(FCSBusy), 32'd0);
        drain();
        chk("t1_len", 32'(obs_q.size()), 32'd17);
        fcs = '0;
        for (int i = 1; i < 17 && i < obs_q.size(); i++) fcs = {fcs[14:0], obs_q[i]};
        chk("t1_fcs", 32'(fcs), 32'h8005);

        // Payload 1 then 16 zeros; receiver-side division over payload+FCS is zero
        obs_q.delete();
        run_frame(1'b1, 17, 64'h1, 1'b1);
        drain();
        chk("t2_len", 32'(obs_q.size()), 32'd33);
        r = 16'h0000;
        foreach (obs_q[i]) r = crc_bit(r, obs_q[i]);
        chk("t2_remainder", 32'(r), 32'd0);

        // FCSen=0 frame, then a random frame started back-to-back with stalls
        obs_q.delete();
        run_frame(1'b0, 3, 64'b101, 1'b1);
        rand_ready = 1'b1;
        rnd = {$urandom, $urandom};
        run_frame(1'b1, 64, rnd, 1'b1);
        drain();
        rand_ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("t34_len", 32'(obs_q.size()), 32'd83);
        r = 16'h0000;
        for (int i = 3; i < obs_q.size(); i++) r = crc_bit(r, obs_q[i]);
        chk("t4_remainder", 32'(r), 32'd0);

        // Abort while the 5th FCS bit is in the slot
        mon_ignore = 1'b1;
        ign_takes  = 0;
        run_frame(1'b1, 1, 64'h1, 1'b0);
        cyc = 0;
        while (ign_takes != 6 && cyc < 100) begin
            @(negedge Clk);
            #1;
            cyc++;
        end
        chk("t5_reach_append", 32'(ign_takes), 32'd6);
        Abort = 1'b1;
        @(posedge Clk);
        #1;
        Abort = 1'b0;
        @(negedge Clk);
        chk("t5_valid", 32'(bus.TxOutValid), 32'd0);
        chk("t5_last",  32'(bus.TxOutLast),  32'd0);
        chk("t5_busy",  32'(FCSBusy),        32'd0);
        mon_ignore = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("t5_quiet", 32'(bus.TxOutValid), 32'd0);
        end
        @(posedge Clk);
        #1;
        obs_q.delete();
        run_frame(1'b1, 1, 64'h1, 1'b1);
        drain();
        fcs = '0;
        for (int i = 1; i < 17 && i < obs_q.size(); i++) fcs = {fcs[14:0], obs_q[i]};
        chk("t5_fcs_reinit", 32'(fcs), 32'h8005);

        // Reset mid-RUN with payload still offered
        mon_ignore = 1'b1;
        StartFCS = 1'b1;
        FCSen    = 1'b1;
        @(posedge Clk);
        #1;
        StartFCS = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        bus.TxBit = 1'b1;
        bus.TxBitValid = 1'b1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        chk("t6_valid", 32'(bus.TxOutValid), 32'd0);
        chk("t6_last",  32'(bus.TxOutLast),  32'd0);
        chk("t6_out",   32'(bus.TxOut),      32'd0);
        chk("t6_busy",  32'(FCSBusy),        32'd0);
        chk("t6_ready", 32'(bus.TxBitReady), 32'd0);
        repeat (4) begin
            @(negedge Clk);
            chk("t6_no_out", 32'({bus.TxOutValid, bus.TxBitReady}), 32'd0);
        end
        bus.TxBitValid = 1'b0;
        mon_ignore = 1'b0;
        @(posedge Clk);
        #1;
        obs_q.delete();
        run_frame(1'b1, 4, 64'b1011, 1'b1);
        drain();
        chk("t6_len", 32'(obs_q.size()), 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
